// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated request/response slave with word RAM, LED and cycle-counter registers
module mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  led_out
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    wait_cnt;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [31:0]   cycle_cnt;
  logic [7:0]    led;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          exec;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          ram_hit;
  logic          led_hit;
  logic          cyc_hit;
  logic          acc_err;
  logic [AW-1:0] ram_idx;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    exec       = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            exec       = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          exec       = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With no wait states the access executes on the accepting edge, straight from the inputs.
  assign acc_we    = (WAIT_CYCLES == 0) ? req_we    : lat_we;
  assign acc_addr  = (WAIT_CYCLES == 0) ? req_addr  : lat_addr;
  assign acc_wdata = (WAIT_CYCLES == 0) ? req_wdata : lat_wdata;

  assign ram_hit = (acc_addr[31:AW+2] == '0);
  assign led_hit = (acc_addr == MMIO_BASE);
  assign cyc_hit = (acc_addr == MMIO_BASE + 32'd4);
  assign acc_err = (acc_addr[1:0] != 2'b00) || !(ram_hit || led_hit || cyc_hit);
  assign ram_idx = acc_addr[AW+1:2];
  assign led_out = led;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      cycle_cnt <= 32'd0;
      led       <= 8'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        wait_cnt  <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (exec) begin
        rsp_err   <= acc_err;
        rsp_rdata <= 32'd0;
        if (!acc_err && !acc_we) begin
          if (ram_hit)      rsp_rdata <= mem[ram_idx];
          else if (led_hit) rsp_rdata <= {24'd0, led};
          else if (cyc_hit) rsp_rdata <= cycle_cnt;
        end
        if (!acc_err && acc_we && !ram_hit && led_hit) led <= acc_wdata[7:0];
      end
    end
  end

  // RAM is not reset; the reset qualifier only blocks a write from an aborted access.
  always_ff @(posedge clk) begin
    if (reset && exec && !acc_err && acc_we && ram_hit) mem[ram_idx] <= acc_wdata;
  end

endmodule
